// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard timing sets, pattern mode encodings and
// the default RGB pixel struct.
package vga_pkg;

    // 640x400 @ 70 Hz timing set
    localparam int VGA400_HZV = 640;
    localparam int VGA400_HZF = 16;
    localparam int VGA400_HZS = 96;
    localparam int VGA400_HZB = 48;
    localparam int VGA400_VTV = 400;
    localparam int VGA400_VTF = 12;
    localparam int VGA400_VTS = 2;
    localparam int VGA400_VTB = 35;

    // 640x480 @ 60 Hz timing set
    localparam int VGA480_HZV = 640;
    localparam int VGA480_HZF = 16;
    localparam int VGA480_HZS = 96;
    localparam int VGA480_HZB = 48;
    localparam int VGA480_VTV = 480;
    localparam int VGA480_VTF = 10;
    localparam int VGA480_VTS = 2;
    localparam int VGA480_VTB = 33;

    // Output colour source selection
    typedef enum logic [1:0] {
        MODE_EXT    = 2'd0,
        MODE_BORDER = 2'd1,
        MODE_BARS   = 2'd2,
        MODE_SOLID  = 2'd3
    } mode_e;

    // Default bits per colour channel and matching pixel layout {r,g,b}
    localparam int CW_DEF = 4;

    typedef struct packed {
        logic [CW_DEF-1:0] r;
        logic [CW_DEF-1:0] g;
        logic [CW_DEF-1:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that carries the raster bundle alongside the
// pixel fetch latency. Reset empties every stage.
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    // Advance every stage by one clock; reset discards all contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel fetch requests at stage 0, colour
// selection at stage PIX_LAT, registered RGB/DE/HS/VS one cycle later.
// Optional macro VGA_TESTPAT_EN adds border/bars/solid test patterns;
// without it the mode/solid_rgb ports are ignored and pixel_in is passed.
// HZW and VTW must both be <= 1024 (10-bit counters).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HZV     = 640,
    parameter int HZF     = 16,
    parameter int HZS     = 96,
    parameter int HZB     = 48,
    parameter int VTV     = 400,
    parameter int VTF     = 12,
    parameter int VTS     = 2,
    parameter int VTB     = 35,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 1,
    parameter int CW      = CW_DEF,
    parameter int PIX_LAT = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] solid_rgb,
    output logic            rd_en,
    output logic [9:0]      rd_x,
    output logic [9:0]      rd_y,
    input  logic [3*CW-1:0] pixel_in,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            de,
    output logic            hs,
    output logic            vs,
    output logic            frame_start,
    output logic            line_start
);

    localparam int HZW = HZB + HZV + HZF + HZS;
    localparam int VTW = VTB + VTV + VTF + VTS;

    localparam logic [9:0] X_LAST = 10'(HZW - 1);
    localparam logic [9:0] Y_LAST = 10'(VTW - 1);
    localparam logic [9:0] X_VIS0 = 10'(HZB);
    localparam logic [9:0] X_VIS1 = 10'(HZB + HZV);
    localparam logic [9:0] X_SYNC = 10'(HZB + HZV + HZF);
    localparam logic [9:0] Y_VIS0 = 10'(VTB);
    localparam logic [9:0] Y_VIS1 = 10'(VTB + VTV);
    localparam logic [9:0] Y_SYNC = 10'(VTB + VTV + VTF);

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    // Syncs travel as "active" flags so an emptied pipeline reads as idle.
    typedef struct packed {
        logic       vis;
        logic       hs_act;
        logic       vs_act;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       ls;
    } tap_t;

    logic [9:0]      x_p0;
    logic [9:0]      y_p0;
    tap_t            tap_p0;
    tap_t            tap_pl;
    logic [3*CW-1:0] colour_pl;

    // ---- stage 0: raster counters and fetch request ----

    // X counts every clock; Y steps only when X wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_p0 <= '0;
            y_p0 <= '0;
        end else if (x_p0 == X_LAST) begin
            x_p0 <= '0;
            y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + 10'd1;
        end else begin
            x_p0 <= x_p0 + 10'd1;
        end
    end

    // Decode the counter position into the bundle that follows the fetch.
    always_comb begin
        tap_p0        = '0;
        tap_p0.vis    = (x_p0 >= X_VIS0) && (x_p0 < X_VIS1) &&
                        (y_p0 >= Y_VIS0) && (y_p0 < Y_VIS1);
        tap_p0.hs_act = (x_p0 >= X_SYNC);
        tap_p0.vs_act = (y_p0 >= Y_SYNC);
        tap_p0.x      = x_p0 - X_VIS0;
        tap_p0.y      = y_p0 - Y_VIS0;
        tap_p0.fs     = tap_p0.vis && (x_p0 == X_VIS0) && (y_p0 == Y_VIS0);
        tap_p0.ls     = tap_p0.vis && (x_p0 == X_VIS0);
    end

    assign rd_en = tap_p0.vis;
    assign rd_x  = tap_p0.x;
    assign rd_y  = tap_p0.y;

    // ---- stages 1..PIX_LAT: bundle waits for the fetched pixel ----

    vga_delay_line #(
        .W     ($bits(tap_t)),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .din   (tap_p0),
        .dout  (tap_pl)
    );

    // ---- stage PIX_LAT: colour selection ----

`ifdef VGA_TESTPAT_EN
    localparam logic [CW-1:0] FULL = '1;
    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [9:0]    X_LASTVIS = 10'(HZV - 1);
    localparam logic [9:0]    Y_LASTVIS = 10'(VTV - 1);

    mode_e mode_q;

    // Bar index x*8/HZV via compares against constant multiples of HZV.
    function automatic logic [2:0] bar_index(input logic [9:0] x);
        logic [12:0] x8;
        logic [2:0]  k;
        x8 = {x, 3'b000};
        k  = '0;
        for (int j = 1; j < 8; j++) begin
            if (x8 >= 13'(j * HZV)) begin
                k = 3'(j);
            end
        end
        return k;
    endfunction

    function automatic logic [3*CW-1:0] pattern_rgb(input mode_e m, input tap_t t,
                                                     input logic [3*CW-1:0] ext,
                                                     input logic [3*CW-1:0] solid);
        logic [3*CW-1:0] res;
        logic [2:0]      k;
        logic            on_edge;
        k       = bar_index(t.x);
        on_edge = (t.x == '0) || (t.x == X_LASTVIS) || (t.y == '0) || (t.y == Y_LASTVIS);
        case (m)
            MODE_BORDER: res = on_edge ? {FULL, FULL, FULL} : {ZERO, ZERO, FULL};
            MODE_BARS:   res = {k[2] ? FULL : ZERO, k[1] ? FULL : ZERO, k[0] ? FULL : ZERO};
            MODE_SOLID:  res = solid;
            default:     res = ext;
        endcase
        return res;
    endfunction

    // Take the new mode only at the raster origin so no frame is torn.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_EXT;
        end else if ((x_p0 == '0) && (y_p0 == '0)) begin
            mode_q <= mode_e'(mode);
        end
    end

    // Pick pattern or fetched pixel; blank outside the visible area.
    always_comb begin
        colour_pl = '0;
        if (tap_pl.vis) begin
            colour_pl = pattern_rgb(mode_q, tap_pl, pixel_in, solid_rgb);
        end
    end
`else
    logic unused_nopat;
    assign unused_nopat = ^{mode, solid_rgb, tap_pl.x, tap_pl.y};

    // Pass the fetched pixel; blank outside the visible area.
    always_comb begin
        colour_pl = '0;
        if (tap_pl.vis) begin
            colour_pl = pixel_in;
        end
    end
`endif

    // ---- output register: all pins share PIX_LAT+1 latency ----

    // Register colour, enable, syncs (polarity applied here) and pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            hs          <= ~HS_ON;
            vs          <= ~VS_ON;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            {r, g, b}   <= colour_pl;
            de          <= tap_pl.vis;
            hs          <= tap_pl.hs_act ? HS_ON : ~HS_ON;
            vs          <= tap_pl.vs_act ? VS_ON : ~VS_ON;
            frame_start <= tap_pl.fs;
            line_start  <= tap_pl.ls;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x400 instance (PIX_LAT=2)
// checked from a vector table, and a miniature-timing instance (PIX_LAT=3)
// for multi-frame, latency and reset sequences.
module tb_vga_timing_gen;

`ifdef VGA_TESTPAT_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst_d, rd_en_d, de_d, hs_d, vs_d, fs_d, ls_d;
    logic [1:0]  mode_d;
    logic [11:0] solid_d, pix_d;
    logic [9:0]  rd_x_d, rd_y_d;
    logic [3:0]  r_d, g_d, b_d;

    // miniature instance: HZW=29, VTW=12, frame = 348 clocks
    logic        rst_s, rd_en_s, de_s, hs_s, vs_s, fs_s, ls_s;
    logic [1:0]  mode_s;
    logic [11:0] solid_s, pix_s;
    logic [9:0]  rd_x_s, rd_y_s;
    logic [3:0]  r_s, g_s, b_s;

    vga_timing_gen u_def (
        .clock(clk), .reset(rst_d), .mode(mode_d), .solid_rgb(solid_d),
        .rd_en(rd_en_d), .rd_x(rd_x_d), .rd_y(rd_y_d), .pixel_in(pix_d),
        .r(r_d), .g(g_d), .b(b_d), .de(de_d), .hs(hs_d), .vs(vs_d),
        .frame_start(fs_d), .line_start(ls_d)
    );

    vga_timing_gen #(
        .HZV(20), .HZF(2), .HZS(3), .HZB(4),
        .VTV(6), .VTF(1), .VTS(2), .VTB(3), .PIX_LAT(3)
    ) u_sm (
        .clock(clk), .reset(rst_s), .mode(mode_s), .solid_rgb(solid_s),
        .rd_en(rd_en_s), .rd_x(rd_x_s), .rd_y(rd_y_s), .pixel_in(pix_s),
        .r(r_s), .g(g_s), .b(b_s), .de(de_s), .hs(hs_s), .vs(vs_s),
        .frame_start(fs_s), .line_start(ls_s)
    );

    // Pixel clients: return {rd_x[3:0], rd_y[3:0], 5} exactly PIX_LAT clocks later.
    logic [11:0] cl_d [2];
    logic [11:0] cl_s [3];
    always @(posedge clk) begin
        cl_d[0] <= {rd_x_d[3:0], rd_y_d[3:0], 4'h5};
        cl_d[1] <= cl_d[0];
        cl_s[0] <= {rd_x_s[3:0], rd_y_s[3:0], 4'h5};
        cl_s[1] <= cl_s[0];
        cl_s[2] <= cl_s[1];
    end
    assign pix_d = cl_d[1];
    assign pix_s = cl_s[2];

    typedef struct {
        int          phase;
        int          cyc;
        logic [11:0] rgb;
        logic [4:0]  ctl;   // {de, hs, vs, frame_start, line_start}
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic addv(input int ph, input int c, input logic [11:0] rgb, input logic [4:0] ctl);
        vec_t v;
        v.phase = ph;
        v.cyc   = c;
        v.rgb   = rgb;
        v.ctl   = ctl;
        tbl.push_back(v);
    endtask

    task automatic run_phase(input int ph);
        foreach (tbl[i]) begin
            if (tbl[i].phase == ph) begin
                step_to(tbl[i].cyc);
                chk($sformatf("vec%0d@%0d", i, tbl[i].cyc),
                    32'({r_d, g_d, b_d, de_d, hs_d, vs_d, fs_d, ls_d}),
                    32'({tbl[i].rgb, tbl[i].ctl}));
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_d = 1'b1; rst_s = 1'b1;
        mode_d = 2'd1; mode_s = 2'd0;
        solid_d = 12'h123; solid_s = 12'hA5C;

        // phase 0: mode 1 (border), output = counter + 3
        addv(0, 3,     12'h000, 5'b01000);
        addv(0, 706,   12'h000, 5'b01000);
        addv(0, 707,   12'h000, 5'b00000);
        addv(0, 802,   12'h000, 5'b00000);
        addv(0, 803,   12'h000, 5'b01000);
        addv(0, 1506,  12'h000, 5'b01000);
        addv(0, 1507,  12'h000, 5'b00000);
        addv(0, 28050, 12'h000, 5'b01000);
        addv(0, 28051, PAT ? 12'hFFF : 12'h005, 5'b11011);
        addv(0, 28052, PAT ? 12'hFFF : 12'h105, 5'b11000);
        addv(0, 28690, PAT ? 12'hFFF : 12'hF05, 5'b11000);
        addv(0, 28691, 12'h000, 5'b01000);
        addv(0, 28851, PAT ? 12'hFFF : 12'h015, 5'b11001);
        addv(0, 28852, PAT ? 12'h00F : 12'h115, 5'b11000);
        // phase 1: mode 2 (bars) after a mid-line reset, row 0
        addv(1, 28050, 12'h000, 5'b01000);
        addv(1, 28051, PAT ? 12'h000 : 12'h005, 5'b11011);
        addv(1, 28130, PAT ? 12'h000 : 12'hF05, 5'b11000);
        addv(1, 28131, PAT ? 12'h00F : 12'h005, 5'b11000);
        addv(1, 28610, PAT ? 12'hFF0 : 12'hF05, 5'b11000);
        addv(1, 28611, PAT ? 12'hFFF : 12'h005, 5'b11000);
        addv(1, 28690, PAT ? 12'hFFF : 12'hF05, 5'b11000);

        repeat (3) @(negedge clk);
        chk("reset_def", 32'({r_d, g_d, b_d, de_d, hs_d, vs_d, fs_d, ls_d, rd_en_d}),
            32'({12'h000, 5'b01000, 1'b0}));
        chk("reset_sm", 32'({r_s, g_s, b_s, de_s, hs_s, vs_s, fs_s, ls_s, rd_en_s}),
            32'({12'h000, 5'b01000, 1'b0}));

        rst_d = 1'b0; cyc = 0;
        run_phase(0);

        // mid-line reset while a visible pixel is on the pins
        rst_d = 1'b1; mode_d = 2'd2;
        #1;
        chk("async_reset_def", 32'({r_d, g_d, b_d, de_d, hs_d, vs_d, fs_d, ls_d, rd_en_d}),
            32'({12'h000, 5'b01000, 1'b0}));
        repeat (2) @(negedge clk);
        rst_d = 1'b0; cyc = 0;
        run_phase(1);
        rst_d = 1'b1;

        // miniature instance, mode 0, PIX_LAT=3: output = counter + 4
        @(negedge clk);
        rst_s = 1'b0; cyc = 0;
        step_to(166);
        chk("rd_17_2", 32'({rd_en_s, rd_x_s, rd_y_s}), 32'({1'b1, 10'd17, 10'd2}));
        step_to(170);
        chk("ext_lat3", 32'({r_s, g_s, b_s, de_s}), 32'({12'h125, 1'b1}));
        step_to(293); chk("vs_before", 32'(vs_s), 32'(1'b0));
        step_to(294); chk("vs_start",  32'(vs_s), 32'(1'b1));
        step_to(351); chk("vs_last",   32'(vs_s), 32'(1'b1));
        step_to(352); chk("vs_end",    32'(vs_s), 32'(1'b0));

        // mode 3 frame, switched to 1 mid-frame
        rst_s = 1'b1; mode_s = 2'd3;
        repeat (2) @(negedge clk);
        rst_s = 1'b0; cyc = 0;
        step_to(174);
        mode_s = 2'd1;
        step_to(216);
        chk("solid_holds", 32'({r_s, g_s, b_s, de_s}), 32'({PAT ? 12'hA5C : 12'h545, 1'b1}));
        step_to(442);
        chk("pre_frame2", 32'({fs_s, de_s}), 32'(2'b00));
        step_to(443);
        chk("frame2_origin", 32'({r_s, g_s, b_s, de_s, fs_s, ls_s}),
            32'({PAT ? 12'hFFF : 12'h005, 3'b111}));
        step_to(564);
        chk("frame2_inner", 32'({r_s, g_s, b_s, de_s}), 32'({PAT ? 12'h00F : 12'h545, 1'b1}));
        step_to(607);
        chk("frame2_corner", 32'({r_s, g_s, b_s, de_s}), 32'({PAT ? 12'hFFF : 12'h355, 1'b1}));

        // reset at X=10, Y=5 for two clocks
        step_to(851);
        rst_s = 1'b1;
        #1;
        chk("async_reset_sm", 32'({r_s, g_s, b_s, de_s, hs_s, vs_s, fs_s, ls_s, rd_en_s}),
            32'({12'h000, 5'b01000, 1'b0}));
        repeat (2) @(negedge clk);
        rst_s = 1'b0; cyc = 0;
        step_to(94);
        chk("fs_not_early", 32'({fs_s, de_s}), 32'(2'b00));
        step_to(95);
        chk("fs_after_reset", 32'({r_s, g_s, b_s, de_s, fs_s, ls_s}),
            32'({PAT ? 12'hFFF : 12'h005, 3'b111}));
        step_to(124);
        chk("ls_row1", 32'({ls_s, fs_s, de_s}), 32'(3'b101));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
